// File: rtl/wb_scoreboard.sv
// Writeback scoreboard and result queue for the integer register file write port.
// Optional operand bypass from the write port is enabled by defining WB_BYPASS_EN.
module wb_scoreboard #(
  parameter  int WIDTH = 32,
  parameter  int SIZE  = 32,
  parameter  int DEPTH = 4,
  localparam int IDX   = $clog2(SIZE),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             claim_en,
  input  logic [IDX-1:0]   claim_index,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [IDX-1:0]   res_index,
  input  logic [WIDTH-1:0] res_data,
  output logic             wr_en,
  output logic [IDX-1:0]   wr_index,
  output logic [WIDTH-1:0] wr_data,
  input  logic [IDX-1:0]   chk1_index,
  input  logic [IDX-1:0]   chk2_index,
  input  logic [IDX-1:0]   chk_rd_index,
  output logic             stall,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [SIZE-1:0]  pending,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX-1:0]   idx;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [SIZE-1:0]   r_pending;
  logic              r_wr_en;
  logic [IDX-1:0]    r_wr_index;
  logic [WIDTH-1:0]  r_wr_data;

  logic              w_push, w_pop;
  entry_t            w_head;
  logic [SIZE-1:0]   w_set, w_clr;
  logic              w_infl1, w_infl2, w_inflrd;
  logic              w_haz1, w_haz2, w_hazrd;

  assign w_head    = r_mem[r_head];
  assign res_ready = (r_count < CW'(DEPTH));
  assign w_push    = res_valid && res_ready;
  assign w_pop     = (r_count != '0);

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{idx: res_index, data: res_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Index-0 results drain silently: the port updates but the write stays disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en    <= 1'b0;
      r_wr_index <= '0;
      r_wr_data  <= '0;
    end else if (w_pop) begin
      r_wr_en    <= (w_head.idx != '0);
      r_wr_index <= w_head.idx;
      r_wr_data  <= w_head.data;
    end else begin
      r_wr_en    <= 1'b0;
    end
  end

  // Clear lands on the pop edge (same edge wr_en rises); a same-edge claim wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (claim_en && claim_index != '0) w_set = SIZE'(1) << claim_index;
    if (w_pop && w_head.idx != '0)     w_clr = SIZE'(1) << w_head.idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign w_infl1  = r_wr_en && (r_wr_index == chk1_index);
  assign w_infl2  = r_wr_en && (r_wr_index == chk2_index);
  assign w_inflrd = r_wr_en && (r_wr_index == chk_rd_index);

`ifdef WB_BYPASS_EN
  assign w_haz1   = (chk1_index != '0) && r_pending[chk1_index];
  assign w_haz2   = (chk2_index != '0) && r_pending[chk2_index];
  assign fwd1_hit = w_infl1 && (chk1_index != '0);
  assign fwd2_hit = w_infl2 && (chk2_index != '0);
`else
  assign w_haz1   = (chk1_index != '0) && (r_pending[chk1_index] || w_infl1);
  assign w_haz2   = (chk2_index != '0) && (r_pending[chk2_index] || w_infl2);
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
`endif
  // A destination being written this cycle is a WAW hazard in both modes.
  assign w_hazrd  = (chk_rd_index != '0) && (r_pending[chk_rd_index] || w_inflrd);

  assign stall    = w_haz1 || w_haz2 || w_hazrd;
  assign wr_en    = r_wr_en;
  assign wr_index = r_wr_index;
  assign wr_data  = r_wr_data;
  assign pending  = r_pending;
  assign count    = r_count;

endmodule
